jt900h_muldiv: RTL and testbench

Multi-cycle multiply/divide unit for the JT900H core. It sits on the other side of the register file's operand/result path. It takes the two latched operands (op0/op1) that the register file presents, and runs MUL, MULS, DIV or DIVS over several clock-enabled cycles. It then hands back a 32-bit result plus the overflow flag for write-back. Byte forms are 8×8 and 16÷8; word forms are 16×16 and 32÷16. The sequencer stalls on `busy` and writes `rslt` to the destination when `done` pulses.

---
 rtl/jt900h_muldiv_pkg.sv | 19 +
 rtl/jt900h_muldiv_sign.sv | 21 ++
 rtl/jt900h_muldiv.sv | 214 +++++++++++++++++++++
 tb/tb_jt900h_muldiv.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/jt900h_muldiv_pkg.sv
// jt900h_muldiv_pkg
// Constants shared between the JT900H sequencer and the multiply/divide unit:
// operation encodings plus small decode helpers for them.
package jt900h_muldiv_pkg;

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_MULS = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;
    localparam logic [1:0] OP_DIVS = 2'd3;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVS);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULS) || (op == OP_DIVS);
    endfunction

endpackage

// File: rtl/jt900h_muldiv_sign.sv
// jt900h_muldiv_sign
// Combinational 32-bit sign helper.
//   din      : value, already sign- or zero-extended to 32 bits
//   abs_mode : 1 = produce |din| (negate when din[31] is set)
//   neg      : used when abs_mode = 0: 1 = negate din, 0 = pass through
//   dout     : result
module jt900h_muldiv_sign (
    input  logic [31:0] din,
    input  logic        abs_mode,
    input  logic        neg,
    output logic [31:0] dout
);

    logic flip;

    always_comb begin
        flip = abs_mode ? din[31] : neg;
        dout = flip ? (~din + 32'd1) : din;
    end

endmodule

// File: rtl/jt900h_muldiv.sv
// jt900h_muldiv
// Multi-cycle MUL/MULS/DIV/DIVS unit, byte (8x8, 16/8) and word (16x16, 32/16).
//   clk, rst_n : clock, async active-low reset
//   cen        : clock enable, all state advances only when set
//   start      : request, accepted while busy = 0
//   op, ws     : operation and size (ws = 1 word)
//   op0, op1   : multiplicand/dividend, multiplier/divisor
//   busy       : operation in progress
//   done       : one-cycle result-valid pulse
//   rslt, v    : packed result and divide overflow flag
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one multiply/divide bit per enabled edge, cnt_q down to 0
// FIX   | sign correction, packing, overflow post-check, done pulse
module jt900h_muldiv import jt900h_muldiv_pkg::*; (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        ws,
    input  logic [31:0] op0,
    input  logic [31:0] op1,
    output logic        busy,
    output logic        done,
    output logic [31:0] rslt,
    output logic        v
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [15:0] opr_q, opr_d;
    logic [1:0]  op_q, op_d;
    logic        ws_q, ws_d;
    logic [31:0] op0_q, op0_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        ovf_q, ovf_d;
    logic [31:0] rslt_q, rslt_d;
    logic        v_q, v_d;
    logic        done_q, done_d;

    // entry: operand extraction and magnitudes
    logic        in_sgn, in_div;
    logic [31:0] a_ext, b_ext, a_mag, b_mag;
    logic        pre_ovf;

    always_comb begin
        in_sgn = op_is_signed(op);
        in_div = op_is_div(op);
        case ({in_div, ws})
            2'b00:   a_ext = in_sgn ? {{24{op0[7]}}, op0[7:0]}   : {24'd0, op0[7:0]};
            2'b01,
            2'b10:   a_ext = in_sgn ? {{16{op0[15]}}, op0[15:0]} : {16'd0, op0[15:0]};
            default: a_ext = op0;
        endcase
        if (ws)
            b_ext = in_sgn ? {{16{op1[15]}}, op1[15:0]} : {16'd0, op1[15:0]};
        else
            b_ext = in_sgn ? {{24{op1[7]}}, op1[7:0]}   : {24'd0, op1[7:0]};
        // a zero divisor is caught here too: any high half is >= 0
        pre_ovf = in_div && (ws ? (a_mag[31:16] >= b_mag[15:0])
                                : (a_mag[15:8]  >= b_mag[7:0]));
    end

    jt900h_muldiv_sign u_abs_a (.din(a_ext), .abs_mode(in_sgn), .neg(1'b0), .dout(a_mag));
    jt900h_muldiv_sign u_abs_b (.din(b_ext), .abs_mode(in_sgn), .neg(1'b0), .dout(b_mag));

    // iteration datapath: acc_q holds {hi, lo} of 2N bits, opr_q the N-bit operand
    logic [16:0] mul_sum17, div_hi17, div_sub17;
    logic [8:0]  mul_sum9, div_hi9, div_sub9;
    logic        div_ge17, div_ge9;
    logic [31:0] mul_next, div_next;

    always_comb begin
        mul_sum17 = {1'b0, acc_q[31:16]} + (acc_q[0] ? {1'b0, opr_q} : 17'd0);
        mul_sum9  = {1'b0, acc_q[15:8]}  + (acc_q[0] ? {1'b0, opr_q[7:0]} : 9'd0);
        mul_next  = ws_q ? {mul_sum17, acc_q[15:1]}
                         : {16'd0, mul_sum9, acc_q[7:1]};

        div_hi17  = acc_q[31:15];
        div_ge17  = div_hi17 >= {1'b0, opr_q};
        div_sub17 = div_hi17 - {1'b0, opr_q};
        div_hi9   = acc_q[15:7];
        div_ge9   = div_hi9 >= {1'b0, opr_q[7:0]};
        div_sub9  = div_hi9 - {1'b0, opr_q[7:0]};
        div_next  = ws_q ? {(div_ge17 ? div_sub17[15:0] : div_hi17[15:0]), acc_q[14:0], div_ge17}
                         : {16'd0, (div_ge9 ? div_sub9[7:0] : div_hi9[7:0]), acc_q[6:0], div_ge9};
    end

    // FIX: sign correction, post-check, packing
    logic        fix_div;
    logic [31:0] quo_mag, rem_mag, fix_in, fix_a, fix_r, quo_lim;
    logic        post_ovf, fix_ovf;
    logic [31:0] fix_rslt;

    always_comb begin
        fix_div = op_is_div(op_q);
        quo_mag = ws_q ? {16'd0, acc_q[15:0]}  : {24'd0, acc_q[7:0]};
        rem_mag = ws_q ? {16'd0, acc_q[31:16]} : {24'd0, acc_q[15:8]};
        fix_in  = fix_div ? quo_mag : acc_q;
        quo_lim = ws_q ? 32'h0000_8000 : 32'h0000_0080;
        // a negative quotient may reach 2^(N-1), a positive one only 2^(N-1)-1
        post_ovf = (op_q == OP_DIVS) && (neg_res_q ? (quo_mag > quo_lim) : (quo_mag >= quo_lim));
        fix_ovf  = ovf_q || post_ovf;
        if (fix_ovf)
            fix_rslt = ws_q ? op0_q : {16'd0, op0_q[15:0]};
        else if (fix_div)
            fix_rslt = ws_q ? {fix_r[15:0], fix_a[15:0]} : {16'd0, fix_r[7:0], fix_a[7:0]};
        else
            fix_rslt = ws_q ? fix_a : {16'd0, fix_a[15:0]};
    end

    jt900h_muldiv_sign u_fix_q (.din(fix_in),  .abs_mode(1'b0), .neg(neg_res_q), .dout(fix_a));
    jt900h_muldiv_sign u_fix_r (.din(rem_mag), .abs_mode(1'b0), .neg(neg_rem_q), .dout(fix_r));

    // bits that are structurally zero or never needed
    logic unused_bits;
    assign unused_bits = ^{b_mag[31:16], fix_r[31:16], div_sub17[16], div_sub9[8]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opr_d     = opr_q;
        op_d      = op_q;
        ws_d      = ws_q;
        op0_d     = op0_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        ovf_d     = ovf_q;
        rslt_d    = rslt_q;
        v_d       = v_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d      = op;
                    ws_d      = ws;
                    op0_d     = op0;
                    neg_res_d = in_sgn && (a_ext[31] ^ b_ext[31]);
                    neg_rem_d = in_sgn && a_ext[31];
                    ovf_d     = pre_ovf;
                    cnt_d     = ws ? 5'd16 : 5'd8;
                    if (in_div) begin
                        acc_d = a_mag;
                        opr_d = b_mag[15:0];
                    end else begin
                        acc_d = ws ? {16'd0, b_mag[15:0]} : {24'd0, b_mag[7:0]};
                        opr_d = a_mag[15:0];
                    end
                    state_d = pre_ovf ? ST_FIX : ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = fix_div ? div_next : mul_next;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1)
                    state_d = ST_FIX;
            end
            ST_FIX: begin
                rslt_d  = fix_rslt;
                v_d     = fix_ovf;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 32'd0;
            opr_q     <= 16'd0;
            op_q      <= OP_MUL;
            ws_q      <= 1'b0;
            op0_q     <= 32'd0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            ovf_q     <= 1'b0;
            rslt_q    <= 32'd0;
            v_q       <= 1'b0;
            done_q    <= 1'b0;
        end else if (cen) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opr_q     <= opr_d;
            op_q      <= op_d;
            ws_q      <= ws_d;
            op0_q     <= op0_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            ovf_q     <= ovf_d;
            rslt_q    <= rslt_d;
            v_q       <= v_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign rslt = rslt_q;
    assign v    = v_q;

endmodule

// File: tb/tb_jt900h_muldiv.sv
module tb_jt900h_muldiv;

    logic        clk = 1'b0;
    logic        rst_n, cen, start, ws;
    logic [1:0]  op;
    logic [31:0] op0, op1;
    logic        busy, done, v;
    logic [31:0] rslt;

    int n_checks = 0;
    int n_fail   = 0;

    jt900h_muldiv dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .op(op), .ws(ws),
        .op0(op0), .op1(op1), .busy(busy), .done(done), .rslt(rslt), .v(v)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  o;
        logic        w;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        vv;
        int          lat;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // signed/unsigned value of the low 'bits' bits of x
    function automatic longint fld(input logic [31:0] x, input int bits, input bit sg);
        longint m, r;
        m = (longint'(1) <<< bits) - 1;
        r = longint'({32'd0, x}) & m;
        if (sg && (((r >>> (bits - 1)) & 1) == 1))
            r = r - (longint'(1) <<< bits);
        return r;
    endfunction

    function automatic longint labs(input longint x);
        return (x < 0) ? -x : x;
    endfunction

    // arithmetic reference: expected result, flag and latency in enabled edges
    task automatic model(input logic [1:0] o, input logic w, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic vv, output int lat);
        int n;
        bit sg, dv, ovf, early;
        longint x, y, p, q, rm;
        logic [63:0] pv, qv, rv;
        n   = w ? 16 : 8;
        sg  = (o == 2'd1) || (o == 2'd3);
        dv  = (o == 2'd2) || (o == 2'd3);
        lat = n + 1;
        vv  = 1'b0;
        r   = 32'd0;
        ovf = 0;
        early = 0;
        if (!dv) begin
            x  = fld(a, n, sg);
            y  = fld(b, n, sg);
            p  = x * y;
            pv = p;
            r  = w ? pv[31:0] : {16'd0, pv[15:0]};
        end else begin
            x = fld(a, 2 * n, sg);
            y = fld(b, n, sg);
            if (y == 0) begin
                ovf = 1; early = 1;
            end else if ((labs(x) / labs(y)) >= (longint'(1) <<< n)) begin
                ovf = 1; early = 1;
            end else begin
                q  = x / y;
                rm = x % y;
                if (sg && ((q > (longint'(1) <<< (n - 1)) - 1) || (q < -(longint'(1) <<< (n - 1)))))
                    ovf = 1;
                qv = q;
                rv = rm;
                r  = w ? {rv[15:0], qv[15:0]} : {16'd0, rv[7:0], qv[7:0]};
            end
            if (ovf) begin
                vv = 1'b1;
                r  = w ? a : {16'd0, a[15:0]};
                if (early) lat = 1;
            end
        end
    endtask

    // cen_mode: 0 = always on, 1 = alternate, 2 = random; poke = extra start while busy
    task automatic run_op(input string tag, input logic [1:0] o, input logic w, input logic [31:0] a,
                          input logic [31:0] b, input int cen_mode, input bit poke,
                          input logic [31:0] exp_r, input logic exp_v, input int exp_lat);
        int  edges;
        bit  en, seen;
        @(negedge clk);
        op = o; ws = w; op0 = a; op1 = b; start = 1'b1; cen = 1'b1;
        @(posedge clk); #1;
        chk({tag, " busy after start"}, 32'(busy), 32'd1);
        chk({tag, " done after start"}, 32'(done), 32'd0);
        start = 1'b0;
        op = 2'($urandom); ws = 1'($urandom); op0 = $urandom; op1 = $urandom;
        edges = 0;
        seen  = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            case (cen_mode)
                0:       cen = 1'b1;
                1:       cen = ~cen;
                default: cen = 1'($urandom_range(0, 1));
            endcase
            start = poke && (edges == 3);
            en = cen;
            @(posedge clk); #1;
            if (en) edges++;
            if (done) seen = 1;
        end
        start = 1'b0;
        chk({tag, " done seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(edges), 32'(exp_lat));
        chk({tag, " rslt"}, rslt, exp_r);
        chk({tag, " v"}, 32'(v), 32'(exp_v));
        chk({tag, " busy at done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic        rw;
        logic [31:0] ra, rb, er;
        logic        ev;
        int          el, ndone;

        tbl[0]  = '{2'd0, 1'b0, 32'h0000_0012, 32'h0000_0034, 32'h0000_03A8, 1'b0, 9};
        tbl[1]  = '{2'd1, 1'b1, 32'h0000_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 1'b0, 17};
        tbl[2]  = '{2'd2, 1'b0, 32'h0000_0064, 32'h0000_0007, 32'h0000_020E, 1'b0, 9};
        tbl[3]  = '{2'd3, 1'b1, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFE_FFF2, 1'b0, 17};
        tbl[4]  = '{2'd2, 1'b0, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b1, 1};
        tbl[5]  = '{2'd2, 1'b0, 32'h0000_0800, 32'h0000_0002, 32'h0000_0800, 1'b1, 1};
        tbl[6]  = '{2'd3, 1'b0, 32'h0000_FF80, 32'h0000_0001, 32'h0000_0080, 1'b0, 9};
        tbl[7]  = '{2'd3, 1'b0, 32'h0000_0080, 32'h0000_0001, 32'h0000_0080, 1'b1, 9};
        tbl[8]  = '{2'd1, 1'b0, 32'h0000_0080, 32'h0000_0080, 32'h0000_4000, 1'b0, 9};
        tbl[9]  = '{2'd0, 1'b1, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0, 17};
        tbl[10] = '{2'd2, 1'b1, 32'h0000_FFFF, 32'h0000_0100, 32'h00FF_00FF, 1'b0, 17};
        tbl[11] = '{2'd3, 1'b0, 32'h0000_0007, 32'h0000_00FE, 32'h0000_01FD, 1'b0, 9};
        tbl[12] = '{2'd2, 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_00FF, 1'b0, 9};
        tbl[13] = '{2'd2, 1'b0, 32'h0000_0100, 32'h0000_0001, 32'h0000_0100, 1'b1, 1};

        rst_n = 1'b0; cen = 1'b1; start = 1'b0; op = 2'd0; ws = 1'b0; op0 = 32'd0; op1 = 32'd0;
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset rslt", rslt, 32'd0);
        chk("reset v", 32'(v), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // back-to-back: each start lands in the cycle where the previous done is high
        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), tbl[i].o, tbl[i].w, tbl[i].a, tbl[i].b, 0, 1'b0,
                   tbl[i].r, tbl[i].vv, tbl[i].lat);

        // done holds while cen is low, clears on the next enabled edge
        @(negedge clk); cen = 1'b0;
        @(posedge clk); #1;
        chk("done hold cen0", 32'(done), 32'd1);
        @(negedge clk); cen = 1'b1;
        @(posedge clk); #1;
        chk("done cleared", 32'(done), 32'd0);
        chk("rslt held", rslt, 32'h0000_0100);

        run_op("mul cen toggle", 2'd0, 1'b0, 32'h0000_0012, 32'h0000_0034, 1, 1'b0, 32'h0000_03A8, 1'b0, 9);

        run_op("start while busy", 2'd0, 1'b0, 32'h0000_0012, 32'h0000_0034, 0, 1'b1, 32'h0000_03A8, 1'b0, 9);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("no queued op done", 32'(ndone), 32'd0);
        chk("no queued op busy", 32'(busy), 32'd0);

        // reset in the middle of CALC
        @(negedge clk);
        op = 2'd0; ws = 1'b1; op0 = 32'h0000_FFFF; op1 = 32'h0000_FFFF; start = 1'b1; cen = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset done", 32'(done), 32'd0);
        chk("midreset rslt", rslt, 32'd0);
        chk("midreset v", 32'(v), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("midreset no done", 32'(ndone), 32'd0);
        run_op("after reset", 2'd1, 1'b1, 32'h0000_FFFE, 32'h0000_0003, 0, 1'b0, 32'hFFFF_FFFA, 1'b0, 17);

        // randomized operations against the arithmetic model
        for (int i = 0; i < 150; i++) begin
            ro = 2'($urandom_range(0, 3));
            rw = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if (ro[1] && ($urandom_range(0, 3) != 0)) begin
                ra = ra >> (rw ? $urandom_range(14, 31) : $urandom_range(20, 31));
                if ($urandom_range(0, 1) == 1) ra = -ra;
            end
            model(ro, rw, ra, rb, er, ev, el);
            run_op($sformatf("rand%0d op%0d ws%0d a%08h b%08h", i, ro, rw, ra, rb), ro, rw, ra, rb,
                   ($urandom_range(0, 1) == 1) ? 2 : 0, 1'b0, er, ev, el);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
